// File: rtl/sample_bus_pkg.sv
// Shared widths, lane ordering and rate constants
// for the fastclk-domain channel samplers.
package sample_bus_pkg;

  localparam int DIV_50MHZ = 6668;

  localparam bit LANE_LSB_FIRST = 1'b0;
  localparam bit LANE_MSB_FIRST = 1'b1;

  function automatic int word_w(int ch_w, int spw);
    return ch_w * spw;
  endfunction

  function automatic int fill_w(int spw);
    return $clog2(spw + 1);
  endfunction

  function automatic int lane_pos(int k, int spw, bit msb_first);
    return msb_first ? (spw - 1 - k) : k;
  endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Valid/ready word channel between the packer
// and its downstream consumer.
interface sample_packer_if #(
  parameter int W = 64
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider; emits a
// one-cycle tick every DIV enabled cycles.
module sample_tick_gen
  import sample_bus_pkg::*;
#(
  parameter int DIV = DIV_50MHZ
) (
  input  logic fastclk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge fastclk) begin
    if (!reset)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sample_packer.sv
// Synchronises din, packs SPW samples per word and
// hands words out through a 1-deep valid/ready slot.
module sample_packer
  import sample_bus_pkg::*;
#(
  parameter int CH_W        = 8,
  parameter int SPW         = 8,
  parameter int DIV         = DIV_50MHZ,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = LANE_LSB_FIRST,
  localparam int WW = word_w(CH_W, SPW),
  localparam int FW = fill_w(SPW)
) (
  input  logic            fastclk,
  input  logic            reset,
  input  logic            en,
  input  logic [CH_W-1:0] din,
  input  logic            flush,
  input  logic            clr_ovf,
  sample_packer_if.master out,
  output logic            overflow,
  output logic [FW-1:0]   fill_cnt
);
  logic [CH_W-1:0] sync_q [SYNC_STAGES];
  logic            tick;
  logic [WW-1:0]   asm_q;
  logic [WW-1:0]   cap;
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_nx;
  logic            complete;
  logic            emit;
  logic            slot_free;

  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .fastclk (fastclk),
    .reset   (reset),
    .en      (en),
    .tick    (tick)
  );

  assign fill_cnt = fill_q;

  // A tick's sample lands in cap before any flush
  // or completion decision looks at the word.
  always_comb begin
    cap     = asm_q;
    fill_nx = fill_q;
    if (tick) begin
      for (int k = 0; k < SPW; k++) begin
        if (fill_q == FW'(k))
          cap[lane_pos(k, SPW, MSB_FIRST)*CH_W +: CH_W] =
            sync_q[SYNC_STAGES-1];
      end
      fill_nx = fill_q + 1'b1;
    end
    complete  = tick && (fill_q == FW'(SPW - 1));
    emit      = complete || (flush && (fill_nx != '0));
    slot_free = !out.valid || out.ready;
  end

  always_ff @(posedge fastclk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      asm_q     <= '0;
      fill_q    <= '0;
      out.data  <= '0;
      out.valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];

      if (out.valid && out.ready)
        out.valid <= 1'b0;

      if (emit) begin
        asm_q  <= '0;
        fill_q <= '0;
        if (slot_free) begin
          out.data  <= cap;
          out.valid <= 1'b1;
        end
      end else begin
        asm_q  <= cap;
        fill_q <= fill_nx;
      end

      if (emit && !slot_free)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end
endmodule
